// File: rtl/mem_io_unit.sv
// Word RAM plus memory-mapped UART transmitter and optional compare timer (macro MEM_IO_TIMER_EN).
// Reads are combinational; writes, UART and timer state update on the rising clk edge.
module mem_io_unit #(
  parameter int MEM_WORDS    = 256,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  input  logic        MemWrite,
  output logic [31:0] Mem_RdData,
  output logic        uart_tx,
  output logic        timer_irq
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [31:0] A_UART_DATA = 32'hFFFF_0000;
  localparam logic [31:0] A_UART_STAT = 32'hFFFF_0004;

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_e;

  logic           ram_hit;
  logic           uart_busy;
  logic [31:0]    tmr_rd;
  logic [31:0]    ram_q [MEM_WORDS];

  uart_state_e    state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     byte_q, byte_d;
  logic           tx_q, tx_d;

  assign ram_hit   = (Mem_WrAddr[31:AW+2] == '0);
  assign uart_busy = (state_q != U_IDLE);
  assign uart_tx   = tx_q;

  // RAM has no reset: contents survive a reset pulse
  always_ff @(posedge clk) begin
    if (MemWrite && ram_hit) begin
      ram_q[Mem_WrAddr[AW+1:2]] <= Mem_WrData;
    end
  end

  always_comb begin
    Mem_RdData = '0;
    if (ram_hit) begin
      Mem_RdData = ram_q[Mem_WrAddr[AW+1:2]];
    end else if (Mem_WrAddr == A_UART_STAT) begin
      Mem_RdData = {31'd0, uart_busy};
    end else begin
      Mem_RdData = tmr_rd;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    byte_d  = byte_q;
    case (state_q)
      U_IDLE: begin
        cnt_d = '0;
        if (MemWrite && (Mem_WrAddr == A_UART_DATA)) begin
          state_d = U_START;
          byte_d  = Mem_WrData[7:0];
        end
      end
      U_START: begin
        if (cnt_q == CNT_LAST) begin
          state_d = U_DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      U_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = U_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        if (cnt_q == CNT_LAST) begin
          state_d = U_IDLE;
          cnt_d   = '0;
        end
      end
    endcase
    // line level follows the next state so uart_tx is a clean registered output
    case (state_d)
      U_START: tx_d = 1'b0;
      U_DATA:  tx_d = byte_d[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= U_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
    end
  end

`ifdef MEM_IO_TIMER_EN
  localparam logic [31:0] A_TMR_COUNT = 32'hFFFF_0010;
  localparam logic [31:0] A_TMR_CMP   = 32'hFFFF_0014;
  localparam logic [31:0] A_TMR_CTRL  = 32'hFFFF_0018;

  logic [31:0] tcnt_q, tcnt_d;
  logic [31:0] tcmp_q, tcmp_d;
  logic        ten_q, ten_d;
  logic        tflag_q, tflag_d;
  logic        tmatch;
  logic        wr_tcnt, wr_tcmp, wr_tctrl;

  assign wr_tcnt   = MemWrite && (Mem_WrAddr == A_TMR_COUNT);
  assign wr_tcmp   = MemWrite && (Mem_WrAddr == A_TMR_CMP);
  assign wr_tctrl  = MemWrite && (Mem_WrAddr == A_TMR_CTRL);
  assign tmatch    = ten_q && (tcnt_q == tcmp_q);
  assign timer_irq = tflag_q;

  always_comb begin
    tcnt_d  = tcnt_q;
    tcmp_d  = tcmp_q;
    ten_d   = ten_q;
    tflag_d = tflag_q;
    if (tmatch) begin
      tcnt_d = '0;
    end else if (ten_q) begin
      tcnt_d = tcnt_q + 32'd1;
    end
    // CPU write wins over count/wrap; match above already used the old value
    if (wr_tcnt) tcnt_d = Mem_WrData;
    if (wr_tcmp) tcmp_d = Mem_WrData;
    if (wr_tctrl) begin
      ten_d = Mem_WrData[0];
      if (Mem_WrData[1]) tflag_d = 1'b0;
    end
    if (tmatch) tflag_d = 1'b1;
  end

  always_comb begin
    case (Mem_WrAddr)
      A_TMR_COUNT: tmr_rd = tcnt_q;
      A_TMR_CMP:   tmr_rd = tcmp_q;
      A_TMR_CTRL:  tmr_rd = {30'd0, tflag_q, ten_q};
      default:     tmr_rd = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt_q  <= '0;
      tcmp_q  <= '1;
      ten_q   <= 1'b0;
      tflag_q <= 1'b0;
    end else begin
      tcnt_q  <= tcnt_d;
      tcmp_q  <= tcmp_d;
      ten_q   <= ten_d;
      tflag_q <= tflag_d;
    end
  end
`else
  assign tmr_rd    = '0;
  assign timer_irq = 1'b0;
`endif

endmodule
